// File: rtl/ysyx_23060203_branch_ctrl.sv
// Branch/jump resolution controller: evaluates B-type conditions, computes target and link, optional perf counters via YSYX_23060203_BRC_PERF_EN.
// Latency: accept -> out_valid/redirect_valid one cycle later; back-to-back at one op per cycle when both consumers are ready.
// Backpressure: the entry is held until write-back and IFU redirect have both fired; in_ready drops while the entry is outstanding.
module ysyx_23060203_branch_ctrl #(
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] RESET_PC_IDLE = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [2:0]      in_funct,
    input  logic [1:0]      in_kind,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_link,
    output logic            out_excp,
    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            flush
`ifdef YSYX_23060203_BRC_PERF_EN
    ,
    output logic [31:0]     perf_br_cnt,
    output logic [31:0]     perf_taken_cnt,
    output logic [31:0]     perf_redir_stall
`endif
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [1:0] K_BRANCH = 2'b00;
    localparam logic [1:0] K_JAL    = 2'b01;
    localparam logic [1:0] K_JALR   = 2'b10;

    logic [0:0]      state;
    logic            wb_done;
    logic            rd_done;

    logic [XLEN:0]   diff;
    logic            cf;
    logic            ovf;
    logic            eq;
    logic            lts;
    logic            ltu;
    logic            cond;
    logic            taken;
    logic            misalign;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;

    logic            busy;
    logic            wb_fire;
    logic            rd_fire;
    logic            complete;
    logic            accept;

    // Subtract-based comparator: diff = src1 - src2 with carry out in the top bit.
    assign diff = {1'b0, in_src1} + {1'b0, ~in_src2} + {{XLEN{1'b0}}, 1'b1};
    assign cf   = diff[XLEN];
    assign eq   = (diff[XLEN-1:0] == '0);
    assign ovf  = (in_src1[XLEN-1] ^ in_src2[XLEN-1]) & (in_src1[XLEN-1] ^ diff[XLEN-1]);
    assign lts  = diff[XLEN-1] ^ ovf;
    assign ltu  = ~cf;

    always_comb begin
        cond = 1'b0;
        if (!in_funct[2]) begin
            cond = in_funct[1] ? 1'b0 : (eq ^ in_funct[0]);
        end else begin
            cond = (in_funct[1] ? ltu : lts) ^ in_funct[0];
        end
    end

    assign taken = (in_kind == K_JAL) | (in_kind == K_JALR) | ((in_kind == K_BRANCH) & cond);

    always_comb begin
        target = in_pc + in_imm;
        if (in_kind == K_JALR) begin
            target = (in_src1 + in_imm) & ~{{(XLEN-1){1'b0}}, 1'b1};
        end
    end

    assign link     = in_pc + XLEN'(4);
    assign misalign = taken & target[1];

    assign busy     = (state == S_BUSY);
    assign wb_fire  = out_valid & out_ready;
    assign rd_fire  = redirect_valid & redirect_ready;
    assign complete = busy & (wb_done | wb_fire) & (rd_done | rd_fire);
    assign in_ready = ~flush & (~busy | complete);
    assign accept   = in_valid & in_ready;

    assign out_valid      = busy & ~wb_done;
    assign redirect_valid = busy & ~rd_done;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= S_IDLE;
            wb_done     <= 1'b0;
            rd_done     <= 1'b0;
            out_link    <= RESET_PC_IDLE;
            redirect_pc <= RESET_PC_IDLE;
            out_excp    <= 1'b0;
        end else if (flush || (complete && !accept)) begin
            state       <= S_IDLE;
            wb_done     <= 1'b0;
            rd_done     <= 1'b0;
            out_link    <= RESET_PC_IDLE;
            redirect_pc <= RESET_PC_IDLE;
            out_excp    <= 1'b0;
        end else if (accept) begin
            state       <= S_BUSY;
            wb_done     <= 1'b0;
            // No redirect handshake for not-taken or misaligned targets.
            rd_done     <= ~(taken & ~misalign);
            out_link    <= link;
            redirect_pc <= target;
            out_excp    <= misalign;
        end else begin
            wb_done     <= wb_done | wb_fire;
            rd_done     <= rd_done | rd_fire;
        end
    end

`ifdef YSYX_23060203_BRC_PERF_EN
    logic r_is_br;
    logic r_taken;

    // A completion that coincides with flush still counts: both handshakes happened.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_is_br          <= 1'b0;
            r_taken          <= 1'b0;
            perf_br_cnt      <= '0;
            perf_taken_cnt   <= '0;
            perf_redir_stall <= '0;
        end else begin
            if (accept) begin
                r_is_br <= (in_kind == K_BRANCH) | (in_kind == 2'b11);
                r_taken <= taken;
            end
            if (complete && r_is_br) begin
                perf_br_cnt <= perf_br_cnt + 32'd1;
            end
            if (complete && r_taken) begin
                perf_taken_cnt <= perf_taken_cnt + 32'd1;
            end
            if (redirect_valid && !redirect_ready) begin
                perf_redir_stall <= perf_redir_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_23060203_branch_ctrl.sv
// Self-checking bench for ysyx_23060203_branch_ctrl: directed scenarios plus randomized traffic against a transaction-level model.
module tb_ysyx_23060203_branch_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic [31:0] in_imm;
    logic [2:0]  in_funct;
    logic [1:0]  in_kind;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_link;
    logic        out_excp;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [31:0] redirect_pc;
    logic        flush;

    int n_vec = 0;
    int n_err = 0;

    // Model: one pending op with the handshakes still owed.
    bit          m_busy = 1'b0;
    bit          m_wbp;
    bit          m_rdp;
    logic [31:0] m_link;
    logic [31:0] m_tgt;
    bit          m_excp;

    ysyx_23060203_branch_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_src1        (in_src1),
        .in_src2        (in_src2),
        .in_imm         (in_imm),
        .in_funct       (in_funct),
        .in_kind        (in_kind),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_link       (out_link),
        .out_excp       (out_excp),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .flush          (flush)
    );

    always #5 clock = ~clock;

    function automatic bit ref_taken(input logic [1:0] k, input logic [2:0] f,
                                     input logic [31:0] a, input logic [31:0] b);
        if (k == 2'd1 || k == 2'd2) return 1'b1;
        if (k != 2'd0) return 1'b0;
        case (f)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) <  $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a <  b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit model_done();
        return m_busy && (!m_wbp || out_ready) && (!m_rdp || redirect_ready);
    endfunction

    function automatic bit model_ready();
        return !flush && (!m_busy || model_done());
    endfunction

    task automatic drive_op(input logic [31:0] pc, input logic [31:0] s1, input logic [31:0] s2,
                            input logic [31:0] imm, input logic [2:0] f, input logic [1:0] k);
        in_valid = 1'b1;
        in_pc    = pc;
        in_src1  = s1;
        in_src2  = s2;
        in_imm   = imm;
        in_funct = f;
        in_kind  = k;
    endtask

    // Advance one clock and update the model from the inputs seen at that edge.
    task automatic clk_step();
        bit          acc, done, wf, rf, tk;
        logic [31:0] pc, s1, s2, imm, tgt;
        logic [2:0]  f;
        logic [1:0]  k;
        bit          rst_now, fl_now;
        wf      = m_busy && m_wbp && out_ready;
        rf      = m_busy && m_rdp && redirect_ready;
        done    = model_done();
        acc     = in_valid && model_ready();
        pc = in_pc; s1 = in_src1; s2 = in_src2; imm = in_imm; f = in_funct; k = in_kind;
        rst_now = !reset;
        fl_now  = flush;
        @(posedge clock);
        if (rst_now || fl_now) begin
            m_busy = 1'b0;
        end else if (acc) begin
            tk     = ref_taken(k, f, s1, s2);
            tgt    = (k == 2'd2) ? ((s1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
            m_busy = 1'b1;
            m_link = pc + 32'd4;
            m_tgt  = tgt;
            m_excp = tk && tgt[1];
            m_wbp  = 1'b1;
            m_rdp  = tk && !m_excp;
        end else if (done) begin
            m_busy = 1'b0;
        end else begin
            if (wf) m_wbp = 1'b0;
            if (rf) m_rdp = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; redirect_ready = 1'b0;
        drive_op(32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0);
        in_valid = 1'b0;
        clk_step();
        clk_step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL rst_redirect_valid got=%b exp=0", redirect_valid); end
        n_vec++; if (out_excp !== 1'b0) begin n_err++; $display("FAIL rst_out_excp got=%b exp=0", out_excp); end
        n_vec++; if (out_link !== 32'h0) begin n_err++; $display("FAIL rst_out_link got=%h exp=0", out_link); end
        n_vec++; if (redirect_pc !== 32'h0) begin n_err++; $display("FAIL rst_redirect_pc got=%h exp=0", redirect_pc); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        reset = 1'b1;
        clk_step();
    endtask

    // Issue one op into an idle controller with both consumers ready.
    task automatic issue(input logic [31:0] pc, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [31:0] imm, input logic [2:0] f, input logic [1:0] k);
        drive_op(pc, s1, s2, imm, f, k);
        clk_step();
        in_valid = 1'b0;
    endtask

    task automatic test_branch_cond();
        out_ready = 1'b1; redirect_ready = 1'b1; flush = 1'b0;
        issue(32'h8000_0000, 32'h1234, 32'h1234, 32'h10, 3'b000, 2'b00);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL beq_out_valid got=%b exp=1", out_valid); end
        n_vec++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL beq_redirect_valid got=%b exp=1", redirect_valid); end
        n_vec++; if (redirect_pc !== 32'h8000_0010) begin n_err++; $display("FAIL beq_redirect_pc got=%h exp=80000010", redirect_pc); end
        n_vec++; if (out_link !== 32'h8000_0004) begin n_err++; $display("FAIL beq_out_link got=%h exp=80000004", out_link); end
        clk_step();
        issue(32'h8000_0000, 32'h1234, 32'h1234, 32'h10, 3'b001, 2'b00);
        n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL bne_redirect_valid got=%b exp=0", redirect_valid); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bne_out_valid got=%b exp=1", out_valid); end
        clk_step();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 32'h1, 32'h10, 3'b110, 2'b00);
        n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL bltu_redirect_valid got=%b exp=0", redirect_valid); end
        clk_step();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 32'h1, 32'h10, 3'b100, 2'b00);
        n_vec++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL blt_redirect_valid got=%b exp=1", redirect_valid); end
        clk_step();
        issue(32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h10, 3'b101, 2'b00);
        n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL bge_redirect_valid got=%b exp=0", redirect_valid); end
        clk_step();
    endtask

    task automatic test_jalr();
        out_ready = 1'b1; redirect_ready = 1'b1; flush = 1'b0;
        issue(32'h8000_0000, 32'h8000_0101, 32'h0, 32'h2, 3'b000, 2'b10);
        n_vec++; if (redirect_pc !== 32'h8000_0102) begin n_err++; $display("FAIL jalr_mis_pc got=%h exp=80000102", redirect_pc); end
        n_vec++; if (out_excp !== 1'b1) begin n_err++; $display("FAIL jalr_mis_excp got=%b exp=1", out_excp); end
        n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL jalr_mis_redirect got=%b exp=0", redirect_valid); end
        clk_step();
        issue(32'h8000_0000, 32'h8000_0101, 32'h0, 32'h0, 3'b000, 2'b10);
        n_vec++; if (redirect_pc !== 32'h8000_0100) begin n_err++; $display("FAIL jalr_pc got=%h exp=80000100", redirect_pc); end
        n_vec++; if (out_excp !== 1'b0) begin n_err++; $display("FAIL jalr_excp got=%b exp=0", out_excp); end
        n_vec++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL jalr_redirect got=%b exp=1", redirect_valid); end
        clk_step();
    endtask

    task automatic test_redirect_stall();
        out_ready = 1'b1; redirect_ready = 1'b0; flush = 1'b0;
        issue(32'h8000_0000, 32'h0, 32'h0, 32'h100, 3'b000, 2'b01);
        drive_op(32'h8000_0200, 32'h5, 32'h5, 32'h40, 3'b001, 2'b00);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (out_valid !== (i == 0)) begin n_err++; $display("FAIL stall_out_valid cyc=%0d got=%b exp=%b", i, out_valid, (i == 0)); end
            n_vec++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL stall_redirect_valid cyc=%0d got=%b exp=1", i, redirect_valid); end
            n_vec++; if (redirect_pc !== 32'h8000_0100) begin n_err++; $display("FAIL stall_redirect_pc cyc=%0d got=%h exp=80000100", i, redirect_pc); end
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
            clk_step();
        end
        redirect_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_in_ready got=%b exp=1", in_ready); end
        clk_step();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_next_out_valid got=%b exp=1", out_valid); end
        n_vec++; if (out_link !== 32'h8000_0204) begin n_err++; $display("FAIL stall_next_link got=%h exp=80000204", out_link); end
        n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL stall_next_redirect got=%b exp=0", redirect_valid); end
        clk_step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs   [4];
        logic [31:0] links [4];
        pcs   = '{32'hFFFF_FFFC, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
        links = '{32'h0000_0000, 32'h0000_0104, 32'h0000_0108, 32'h0000_010C};
        out_ready = 1'b1; redirect_ready = 1'b0; flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_op(pcs[i], 32'h77, 32'h77, 32'h8, 3'b001, 2'b00);
            #1;
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready op=%0d got=%b exp=1", i, in_ready); end
            clk_step();
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_out_valid op=%0d got=%b exp=1", i, out_valid); end
            n_vec++; if (out_link !== links[i]) begin n_err++; $display("FAIL b2b_out_link op=%0d got=%h exp=%h", i, out_link, links[i]); end
        end
        in_valid = 1'b0;
        clk_step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush_reset();
        out_ready = 1'b1; redirect_ready = 1'b0; flush = 1'b0;
        issue(32'h8000_0000, 32'h0, 32'h0, 32'h20, 3'b000, 2'b01);
        clk_step();
        n_vec++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL flush_pre_redirect got=%b exp=1", redirect_valid); end
        drive_op(32'h9000_0000, 32'h1, 32'h1, 32'h4, 3'b000, 2'b00);
        flush = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        clk_step();
        flush = 1'b0; in_valid = 1'b0;
        n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL flush_redirect got=%b exp=0", redirect_valid); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
        n_vec++; if (redirect_pc !== 32'h0) begin n_err++; $display("FAIL flush_redirect_pc got=%h exp=0", redirect_pc); end
        out_ready = 1'b0;
        issue(32'h8000_0000, 32'h8000_0101, 32'h0, 32'h2, 3'b000, 2'b10);
        n_vec++; if (out_excp !== 1'b1) begin n_err++; $display("FAIL rstbusy_pre_excp got=%b exp=1", out_excp); end
        reset = 1'b0;
        clk_step();
        reset = 1'b1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstbusy_out_valid got=%b exp=0", out_valid); end
        n_vec++; if (out_excp !== 1'b0) begin n_err++; $display("FAIL rstbusy_out_excp got=%b exp=0", out_excp); end
        n_vec++; if (out_link !== 32'h0) begin n_err++; $display("FAIL rstbusy_out_link got=%h exp=0", out_link); end
        n_vec++; if (redirect_pc !== 32'h0) begin n_err++; $display("FAIL rstbusy_redirect_pc got=%h exp=0", redirect_pc); end
        n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL rstbusy_redirect got=%b exp=0", redirect_valid); end
    endtask

    task automatic test_random();
        logic [31:0] edge_vals [5];
        logic [31:0] s1, e_link, e_tgt;
        edge_vals = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        for (int c = 0; c < 3000; c++) begin
            reset          = ($urandom_range(0, 99) != 0);
            flush          = ($urandom_range(0, 15) == 0);
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_ready = ($urandom_range(0, 3) != 0);
            s1 = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
            drive_op($urandom, s1,
                     ($urandom_range(0, 3) == 0) ? s1 :
                     (($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom),
                     $urandom, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            in_valid = ($urandom_range(0, 3) != 0);
            #1;
            n_vec++; if (in_ready !== model_ready()) begin n_err++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", c, in_ready, model_ready()); end
            clk_step();
            e_link = m_busy ? m_link : 32'h0;
            e_tgt  = m_busy ? m_tgt  : 32'h0;
            n_vec++; if (out_valid !== (m_busy && m_wbp)) begin n_err++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", c, out_valid, m_busy && m_wbp); end
            n_vec++; if (redirect_valid !== (m_busy && m_rdp)) begin n_err++; $display("FAIL rnd_redirect_valid cyc=%0d got=%b exp=%b", c, redirect_valid, m_busy && m_rdp); end
            n_vec++; if (out_excp !== (m_busy && m_excp)) begin n_err++; $display("FAIL rnd_out_excp cyc=%0d got=%b exp=%b", c, out_excp, m_busy && m_excp); end
            n_vec++; if (out_link !== e_link) begin n_err++; $display("FAIL rnd_out_link cyc=%0d got=%h exp=%h", c, out_link, e_link); end
            n_vec++; if (redirect_pc !== e_tgt) begin n_err++; $display("FAIL rnd_redirect_pc cyc=%0d got=%h exp=%h", c, redirect_pc, e_tgt); end
        end
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_branch_cond();
        test_jalr();
        test_redirect_stall();
        test_back_to_back();
        test_flush_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_23060203_branch_ctrl.md
Name: ysyx_23060203_branch_ctrl

Overview:
Sequencing controller for branch/jump resolution between IDU and EXU write-back/IFU. Accepts one decoded control-transfer op per handshake and evaluates the RV32 B-type condition with its own comparator (subtract-based eq/lts/ltu). Computes target and link value, then holds the result until both the write-back consumer and the IFU redirect port have accepted it. Single entry, registered outputs, back-to-back capable.

Parameters:
XLEN, 32, datapath width; only 32 supported
RESET_PC_IDLE, 32'h0, value driven on redirect_pc and out_link while idle/reset

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset (0 = reset)
in_valid  in  1  op available from IDU
in_ready  out  1  controller can accept op
in_pc  in  32  pc of op
in_src1  in  32  rs1 value
in_src2  in  32  rs2 value
in_imm  in  32  sign-extended immediate
in_funct  in  3  B-type funct3
in_kind  in  2  00 branch, 01 jal, 10 jalr, 11 reserved (treated as not-taken branch)
out_valid  out  1  link/result ready for write-back
out_ready  in  1  write-back accepts
out_link  out  32  pc+4
out_excp  out  1  taken target misaligned (target[1]=1)
redirect_valid  out  1  IFU must refetch from redirect_pc
redirect_ready  in  1  IFU accepts redirect
redirect_pc  out  32  resolved target
flush  in  1  pipeline flush (exception/trap)

Behaviour:
- Reset (reset==0 at clock edge): state IDLE, out_valid=0, redirect_valid=0, out_excp=0, out_link=redirect_pc=RESET_PC_IDLE, done flags cleared. Reset wins over all events, including mid-handshake.
- States: IDLE, BUSY. Accept fire = in_valid & in_ready.
- in_ready = ~flush & (IDLE | (BUSY & entry completes this cycle)); back-to-back ops at one per cycle when consumers are always ready.
- On accept: register result; next cycle BUSY, out_valid=1. Latency accept->out_valid = 1 cycle.
- Condition: diff = src1 + ~src2 + 1 (33-bit, carry cf); eq = diff==0; lts = sign ^ overflow; ltu = ~cf. funct[2]=0 -> eq; funct[2:1]=10 -> lts; 11 -> ltu; result XOR funct[0]. funct 010/011 -> not taken.
- taken = jal | jalr | (branch & cond).
- target: jalr -> (src1+imm) & ~1; else pc+imm; 32-bit wrap-around, no overflow flag. link = pc+4, wraps 0xFFFFFFFC->0.
- excp = taken & target[1]. If excp: redirect_valid stays 0, out_excp=1.
- redirect_valid=1 in BUSY iff taken & ~excp & redirect not yet done. Not-taken branch: no redirect.
- Two done flags (wb_done, rd_done); each set on its own fire (out_valid&out_ready, redirect_valid&redirect_ready), preset when that handshake is not required. Entry completes when both are done, including same-cycle fire of both. On completion: IDLE, or BUSY with the new op if accepted the same cycle.
- valid signals, once asserted, stay stable with constant payload until fired.
- flush: any state -> IDLE next cycle; pending out/redirect dropped; no accept that cycle. flush in the same cycle as a fire: the fire counts, then the entry is discarded.

Optional Feature:
YSYX_23060203_BRC_PERF_EN: defined -> adds output ports perf_br_cnt[31:0] (branch kind ops completed), perf_taken_cnt[31:0] (taken completions), perf_redir_stall[31:0] (cycles with redirect_valid & ~redirect_ready); counters reset to 0, wrap at 2^32, unchanged by flush-dropped entries. Undefined -> ports and logic absent; behaviour otherwise identical.

Test Plan:
- beq src1=src2=0x1234, pc=0x80000000, imm=0x10, both readys=1 -> next cycle out_valid=1, redirect_valid=1, redirect_pc=0x80000010, out_link=0x80000004; bne same operands -> redirect_valid=0.
- bltu src1=0xFFFFFFFF, src2=1 -> not taken; blt same operands -> taken; bge src1=0x80000000, src2=0x7FFFFFFF -> not taken.
- jalr src1=0x80000101, imm=0x2 -> redirect_pc=0x80000102 (bit0 cleared), out_excp=1, no redirect; src1=0x80000101, imm=0 -> redirect_pc=0x80000100.
- jal with redirect_ready low 3 cycles, out_ready=1 -> out fires cycle 1, redirect_valid held 3 cycles with stable pc, in_ready=0 until redirect fires, new op accepted that cycle.
- Stream of 4 not-taken branches, out_ready=1 -> one accept per cycle, 4 consecutive out_valid pulses.
- flush asserted while BUSY waiting on redirect -> IDLE next cycle, redirect_valid=0; reset=0 mid-BUSY -> all outputs at reset values next cycle.
